// File: rtl/vgg_stream_pkg.sv
// Shared types and defaults for the frame streaming controller.
// Optional stall counter in frame_stream_ctrl is enabled by FRAME_STALL_CNT_EN.
package vgg_stream_pkg;

   localparam int unsigned DEF_DWIDTH = 8;
   localparam int unsigned DEF_WIDTH  = 56;
   localparam int unsigned DEF_HEIGHT = 56;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FLUSH  = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   // One flush row of zero pads: a full row plus a border column on each side.
   function automatic int unsigned pad_count(input int unsigned width);
      return width + 2;
   endfunction

endpackage

// File: rtl/frame_stream_ctrl_rowcol_counter.sv
// Column/row position counter with a programmable column wrap point.
// Shared by the pixel and pad phases of frame_stream_ctrl.
module rowcol_counter #(
   parameter int unsigned CW = 3,
   parameter int unsigned RW = 2
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [CW-1:0] i_col_last,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row
);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_en) begin
         if (r_col == i_col_last) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col = r_col;
   assign o_row = r_row;

endmodule

// File: rtl/frame_stream_ctrl.sv
// Streams one frame from a show-ahead FIFO to a ready/valid sink, then a row of pads.
// Define FRAME_STALL_CNT_EN to add the stall_cnt output.
module frame_stream_ctrl
   import vgg_stream_pkg::*;
#(
   parameter int unsigned DWIDTH = DEF_DWIDTH,
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   output logic                         busy,
   input  logic                         fifo_empty,
   input  logic [DWIDTH-1:0]            fifo_q,
   output logic                         fifo_rdreq,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [DWIDTH-1:0]            out_data,
   output logic                         out_pad,
   output logic [$clog2(WIDTH+2)-1:0]   out_col,
   output logic [$clog2(HEIGHT+1)-1:0]  out_row,
   output logic                         frame_done
`ifdef FRAME_STALL_CNT_EN
   ,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int unsigned CW   = $clog2(WIDTH+2);
   localparam int unsigned RW   = $clog2(HEIGHT+1);
   localparam int unsigned PW   = $clog2(WIDTH*HEIGHT+1);
   localparam int unsigned PADS = pad_count(WIDTH);
   localparam int unsigned PADW = $clog2(PADS+1);

   localparam logic [PW-1:0]   LAST_POP        = PW'(WIDTH*HEIGHT-1);
   localparam logic [PADW-1:0] LAST_PAD        = PADW'(PADS-1);
   localparam logic [CW-1:0]   STREAM_COL_LAST = CW'(WIDTH-1);
   localparam logic [CW-1:0]   FLUSH_COL_LAST  = CW'(PADS-1);
   localparam logic [RW-1:0]   PAD_ROW         = RW'(HEIGHT);

   state_t          r_state;
   logic [PW-1:0]   r_pop_cnt;
   logic [PADW-1:0] r_pad_cnt;

   logic            w_ld;
   logic            w_pop;
   logic            w_pad_ld;
   logic            w_last_pad;
   logic            w_cnt_clr;
   logic            w_cnt_en;
   logic [CW-1:0]   w_col_last;
   logic [CW-1:0]   w_col;
   logic [RW-1:0]   w_row;

   assign w_ld       = !out_valid || out_ready;
   assign w_pop      = (r_state == S_STREAM) && !fifo_empty && w_ld;
   assign w_pad_ld   = (r_state == S_FLUSH) && w_ld;
   assign w_last_pad = w_pad_ld && (r_pad_cnt == LAST_PAD);
   assign fifo_rdreq = w_pop;
   assign busy       = (r_state != S_IDLE);

   // The last pixel wraps col to 0 and row to HEIGHT, so the pad phase starts
   // at column 0 without a reload; the final pad clears for the next frame.
   assign w_cnt_clr  = ((r_state == S_IDLE) && start) || w_last_pad;
   assign w_cnt_en   = w_pop || w_pad_ld;
   assign w_col_last = (r_state == S_FLUSH) ? FLUSH_COL_LAST : STREAM_COL_LAST;

   rowcol_counter #(
      .CW (CW),
      .RW (RW)
   ) u_rowcol (
      .clk        (clk),
      .resetn     (resetn),
      .i_clr      (w_cnt_clr),
      .i_en       (w_cnt_en),
      .i_col_last (w_col_last),
      .o_col      (w_col),
      .o_row      (w_row)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_pop_cnt  <= '0;
         r_pad_cnt  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_pad    <= 1'b0;
         out_col    <= '0;
         out_row    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_STREAM;
                  r_pop_cnt <= '0;
                  r_pad_cnt <= '0;
               end
            end
            S_STREAM: begin
               if (w_pop) begin
                  out_valid <= 1'b1;
                  out_data  <= fifo_q;
                  out_pad   <= 1'b0;
                  out_col   <= w_col;
                  out_row   <= w_row;
                  r_pop_cnt <= r_pop_cnt + 1'b1;
                  if (r_pop_cnt == LAST_POP) begin
                     r_state   <= S_FLUSH;
                     r_pad_cnt <= '0;
                  end
               end else if (w_ld) begin
                  out_valid <= 1'b0;
               end
            end
            S_FLUSH: begin
               if (w_ld) begin
                  out_valid <= 1'b1;
                  out_data  <= '0;
                  out_pad   <= 1'b1;
                  out_col   <= w_col;
                  out_row   <= PAD_ROW;
                  r_pad_cnt <= r_pad_cnt + 1'b1;
                  if (r_pad_cnt == LAST_PAD) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_ld) begin
                  out_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FRAME_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_stall_cnt <= '0;
      end else if (busy && out_valid && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Self-checking bench for frame_stream_ctrl (WIDTH=4, HEIGHT=3) against a beat-list model.
// Stall counter checks are built when FRAME_STALL_CNT_EN is defined.
`timescale 1ns/1ps
module tb_frame_stream_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned W     = 4;
   localparam int unsigned H     = 3;
   localparam int unsigned NPIX  = W*H;
   localparam int unsigned NPAD  = W+2;
   localparam int unsigned NBEAT = NPIX+NPAD;
   localparam int unsigned CW    = $clog2(W+2);
   localparam int unsigned RW    = $clog2(H+1);

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_q = '0;
   logic          fifo_rdreq;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_pad;
   logic [CW-1:0] out_col;
   logic [RW-1:0] out_row;
   logic          frame_done;
`ifdef FRAME_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   frame_stream_ctrl #(
      .DWIDTH (DW),
      .WIDTH  (W),
      .HEIGHT (H)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .busy       (busy),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_pad    (out_pad),
      .out_col    (out_col),
      .out_row    (out_row),
      .frame_done (frame_done)
`ifdef FRAME_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          pad;
      logic [CW-1:0] col;
      logic [RW-1:0] row;
   } beat_t;

   // mode: 0 ready always high, 1 ready toggles 1010..., 2 random ready and random empties
   typedef struct {
      int unsigned mode;
      bit          rand_px;
      int unsigned gap_after;
      int unsigned gap_len;
      bit          restart_in_flush;
      int unsigned exp_xfers;
      int unsigned exp_done;
   } vec_t;

   localparam int unsigned NVEC = 7;
   vec_t          tbl [NVEC];

   logic [DW-1:0] fq [$];
   bit            force_empty;
   beat_t         got [$];
   logic [DW-1:0] pix [NPIX];
   beat_t         exp_beats [NBEAT];

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int unsigned   done_cnt, pops, cyc, rule_viol, last_xfer_cyc, done_cyc;
   bit            stall_prev, bubble_seen;
   beat_t         prev_beat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void refresh();
      fifo_empty = force_empty || (fq.size() == 0);
      fifo_q     = (fq.size() != 0) ? fq[0] : '0;
   endfunction

   task automatic clear_stats();
      got.delete();
      done_cnt = 0; pops = 0; cyc = 0; rule_viol = 0;
      last_xfer_cyc = 0; done_cyc = 0;
      stall_prev = 0; bubble_seen = 0;
      prev_beat = '0;
   endtask

   // One clock: drive after the falling edge, observe 1ns later, let the FIFO pop after the rising edge.
   task automatic cycle(input bit st, input bit rdy, input bit fe);
      bit    pop;
      beat_t b;
      @(negedge clk);
      start = st;
      out_ready = rdy;
      force_empty = fe;
      refresh();
      #1;
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (fifo_rdreq && (fifo_empty || !busy)) rule_viol++;
      if (fifo_rdreq && out_valid && !out_ready) rule_viol++;
      b.data = out_data;
      b.pad  = out_pad;
      b.col  = out_col;
      b.row  = out_row;
      if (stall_prev && (!out_valid || (b != prev_beat))) rule_viol++;
      if (fe && busy && !out_valid) bubble_seen = 1;
      if (out_valid && out_ready) begin
         got.push_back(b);
         last_xfer_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_beat = b;
      pop = fifo_rdreq;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (pop) begin
         void'(fq.pop_front());
         pops++;
      end
      refresh();
      cyc++;
   endtask

   // Reference frame: every pixel in raster order, then one row of zero pads at row H.
   task automatic build_exp();
      for (int i = 0; i < NPIX; i++) begin
         exp_beats[i].data = pix[i];
         exp_beats[i].pad  = 1'b0;
         exp_beats[i].col  = CW'(i % W);
         exp_beats[i].row  = RW'(i / W);
      end
      for (int p = 0; p < NPAD; p++) begin
         exp_beats[NPIX+p].data = '0;
         exp_beats[NPIX+p].pad  = 1'b1;
         exp_beats[NPIX+p].col  = CW'(p);
         exp_beats[NPIX+p].row  = RW'(H);
      end
   endtask

   task automatic load_frame(input bit rand_px);
      for (int i = 0; i < NPIX; i++) begin
         pix[i] = rand_px ? DW'($urandom) : DW'(i+1);
         fq.push_back(pix[i]);
      end
      refresh();
      build_exp();
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int unsigned gap_left;
      int unsigned n;
      bit          injected;
      bit          rdy, fe, st;
      clear_stats();
      load_frame(v.rand_px);
      gap_left = v.gap_len;
      injected = 0;
      cycle(1'b1, 1'b1, 1'b0);
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         case (v.mode)
            0:       rdy = 1'b1;
            1:       rdy = (n % 2 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         fe = (v.mode == 2) && ($urandom_range(0, 4) == 0);
         if (gap_left > 0 && pops == v.gap_after) begin
            fe = 1'b1;
            gap_left--;
         end
         st = 1'b0;
         if (v.restart_in_flush && !injected && pops == NPIX && busy) begin
            st = 1'b1;
            injected = 1;
         end
         cycle(st, rdy, fe);
         n++;
      end
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      check($sformatf("xfers_v%0d", idx), got.size(), v.exp_xfers);
      check($sformatf("done_cnt_v%0d", idx), done_cnt, v.exp_done);
      check($sformatf("done_timing_v%0d", idx), done_cyc, last_xfer_cyc + 1);
      check($sformatf("rules_v%0d", idx), rule_viol, 0);
      check($sformatf("idle_v%0d", idx), busy, 0);
      check($sformatf("fifo_left_v%0d", idx), fq.size(), 0);
      if (v.restart_in_flush) check($sformatf("restart_seen_v%0d", idx), injected, 1);
      if (v.gap_len > 0) check($sformatf("bubble_v%0d", idx), bubble_seen, 1);
      for (int i = 0; i < got.size() && i < NBEAT; i++)
         check($sformatf("beat%0d_v%0d", i, idx), got[i], exp_beats[i]);
      fq.delete();
      force_empty = 0;
      refresh();
   endtask

   initial begin
      int unsigned n;
      int unsigned sz;

      tbl[0] = '{0, 1'b0, 0, 0, 1'b0, NBEAT, 1};
      tbl[1] = '{1, 1'b0, 0, 0, 1'b0, NBEAT, 1};
      tbl[2] = '{0, 1'b0, 6, 5, 1'b0, NBEAT, 1};
      tbl[3] = '{0, 1'b0, 0, 0, 1'b1, NBEAT, 1};
      tbl[4] = '{1, 1'b1, 0, 0, 1'b0, NBEAT, 1};
      tbl[5] = '{2, 1'b1, 3, 4, 1'b0, NBEAT, 1};
      tbl[6] = '{2, 1'b1, 9, 2, 1'b0, NBEAT, 1};

      refresh();
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", {busy, out_valid, out_pad, frame_done, fifo_rdreq}, 0);
      check("reset_data_pos", {out_data, out_col, out_row}, 0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(i, tbl[i]);

      // Reset in the middle of a frame.
      clear_stats();
      load_frame(1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      n = 0;
      while (got.size() < 7 && n < 100) begin
         cycle(1'b0, 1'b1, 1'b0);
         n++;
      end
      check("rst_reach7", got.size(), 7);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_async_ctrl", {busy, out_valid, out_pad, frame_done, fifo_rdreq}, 0);
      check("rst_async_data", {out_data, out_col, out_row}, 0);
      sz = fq.size();
      @(negedge clk);
      resetn = 1'b1;
      done_cnt = 0;
      repeat (10) cycle(1'b0, 1'b1, 1'b0);
      check("rst_stay_idle", busy, 0);
      check("rst_no_valid", out_valid, 0);
      check("rst_no_done", done_cnt, 0);
      check("rst_fifo_kept", fq.size(), sz);
      fq.delete();
      refresh();

`ifdef FRAME_STALL_CNT_EN
      clear_stats();
      load_frame(1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check("stall_valid", out_valid, 1);
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("stall_cnt10", stall_cnt, 10);
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         cycle(1'b0, 1'b1, 1'b0);
         n++;
      end
      check("stall_frame_done", done_cnt, 1);
      load_frame(1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      check("stall_cleared", stall_cnt, 0);
      done_cnt = 0;
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         cycle(1'b0, 1'b1, 1'b0);
         n++;
      end
      check("stall_frame2_done", done_cnt, 1);
      fq.delete();
      refresh();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
